reg_file_sb: RTL
================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register index width; depth = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  in  1  synchronous active-high reset.
REQ-007 SHALL have port raddr  in  NUM_RD*ADDR_WIDTH  read indices; port i = bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 SHALL have port rdata  out  NUM_RD*DATA_WIDTH  read data, same packing.
REQ-009 SHALL have port rbusy  out  NUM_RD  per-port: addressed register has a pending write.
REQ-010 SHALL have port wen  in  1  writeback valid.
REQ-011 SHALL have port waddr  in  ADDR_WIDTH  writeback index.
REQ-012 SHALL have port wdata  in  DATA_WIDTH  writeback data.
REQ-013 SHALL have port alloc_en  in  1  issue request: mark alloc_addr pending.
REQ-014 SHALL have port alloc_addr  in  ADDR_WIDTH  destination being issued.
REQ-015 SHALL have port alloc_stall  out  1  combinational: alloc rejected this cycle.
REQ-016 SHALL have port flush  in  1  clear all pending marks (pipeline flush).
REQ-017 SHALL have port busy_cnt  out  ADDR_WIDTH+1  registered count of pending registers.
REQ-018 SHALL have port wb_orphan  out  1  registered one-cycle pulse: writeback hit non-pending register.

Function
REQ-019 SHALL hold register array rf and busy vector busy[2**ADDR_WIDTH]; index 0 never written, never busy, always reads 0.
REQ-020 SHALL write rf[waddr] <= wdata on edge when wen && waddr!=0 && !rst, regardless of busy state.
REQ-021 SHALL drive rdata[i] combinationally: 0 if raddr[i]==0; else wdata if BYPASS && wen && waddr==raddr[i]; else rf[raddr[i]].
REQ-022 SHALL drive rbusy[i] = busy[raddr[i]] && !(BYPASS && wen && waddr==raddr[i]); rbusy[i]=0 for index 0.
REQ-023 SHALL assert alloc_stall when alloc_en && alloc_addr!=0 && busy[alloc_addr] && !(wen && waddr==alloc_addr); otherwise 0.
REQ-024 SHALL set busy[alloc_addr] on edge when alloc_en && alloc_addr!=0 && !alloc_stall && !flush.
REQ-025 SHALL clear busy[waddr] on edge when wen && waddr!=0, unless same-cycle accepted alloc to same index, in which case busy stays 1.
REQ-026 SHALL pulse wb_orphan=1 next cycle when wen && waddr!=0 && !busy[waddr] && !flush; write still performed.
REQ-027 SHALL on flush clear every busy bit on edge; flush overrides alloc; concurrent wen still writes rf.
REQ-028 SHALL update busy_cnt each edge to popcount of next busy vector; never exceeds 2**ADDR_WIDTH-1.
REQ-029 SHALL treat alloc_en with alloc_addr==0 as accepted no-op (no stall, no mark).

Reset
REQ-030 SHALL on rst edge: clear all rf entries to 0, all busy bits, busy_cnt=0, wb_orphan=0.
REQ-031 SHALL ignore wen, alloc_en, flush during rst cycle; reset mid-operation discards pending marks.
REQ-032 SHALL present after reset: rdata=0, rbusy=0, alloc_stall=0 for any addresses until first write/alloc.

Verification
REQ-033 SHALL cover: rst, wen waddr=5 wdata=0xDEADBEEF, next cycle raddr0=5 -> rdata0=0xDEADBEEF, rbusy0=0; wen waddr=0 wdata=0x1 -> raddr=0 reads 0.
REQ-034 SHALL cover: alloc 7; next cycle raddr1=7 -> rbusy1=1, busy_cnt=1; alloc 7 again -> alloc_stall=1; wen 7 data 0x55 same cycle as read -> rdata1=0x55, rbusy1=0 (BYPASS=1), busy_cnt=0 after edge.
REQ-035 SHALL cover: reg 9 pending, same cycle wen 9 and alloc 9 -> alloc_stall=0, busy[9] stays 1, busy_cnt unchanged.
REQ-036 SHALL cover: alloc 3,4,6 on consecutive cycles -> busy_cnt=3; flush with alloc 8 -> busy_cnt=0, rbusy for 8 = 0.
REQ-037 SHALL cover: wen waddr=12 with reg 12 not pending -> wb_orphan=1 for exactly one cycle, rf[12] updated.
REQ-038 SHALL cover: BYPASS=0, NUM_RD=3, wen 2 data 0xA read 2 same cycle -> old value returned; after reset mid-pending, all rbusy=0, busy_cnt=0.

Source files
------------

// File: rtl/reg_file_sb.sv
// Register file with per-register scoreboard: pending-write marks set at issue,
// cleared at writeback, optional same-cycle write-to-read forwarding.
module reg_file_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rbusy,
  input  logic                         wen,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic                         alloc_en,
  input  logic [ADDR_WIDTH-1:0]        alloc_addr,
  output logic                         alloc_stall,
  input  logic                         flush,
  output logic [ADDR_WIDTH:0]          busy_cnt,
  output logic                         wb_orphan
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf_q [DEPTH];
  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [ADDR_WIDTH:0]   busy_cnt_q, busy_cnt_d;
  logic                  wb_orphan_q, wb_orphan_d;
  logic                  wr_hit;
  logic                  alloc_ok;

  function automatic logic [ADDR_WIDTH:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_WIDTH:0] c;
    c = '0;
    for (int k = 0; k < DEPTH; k++) c = c + {{ADDR_WIDTH{1'b0}}, v[k]};
    return c;
  endfunction

  assign wr_hit = wen && (waddr != '0);

  // A writeback to the same index in this cycle retires the pending mark,
  // so a re-issue of that register does not need to stall.
  assign alloc_stall = alloc_en && (alloc_addr != '0) && busy_q[alloc_addr]
                       && !(wen && (waddr == alloc_addr));
  assign alloc_ok    = alloc_en && (alloc_addr != '0) && !alloc_stall && !flush;

  genvar g;
  for (g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  fwd;
    assign ra  = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign fwd = (BYPASS != 0) && wen && (waddr == ra);
    assign rdata[g*DATA_WIDTH +: DATA_WIDTH] = (ra == '0) ? '0 : (fwd ? wdata : rf_q[ra]);
    assign rbusy[g] = (ra != '0) && busy_q[ra] && !fwd;
  end

  // Set after clear: an accepted re-issue of the written index keeps it pending.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_hit)   busy_d[waddr]      = 1'b0;
      if (alloc_ok) busy_d[alloc_addr] = 1'b1;
    end
    busy_cnt_d  = popcount(busy_d);
    wb_orphan_d = wr_hit && !busy_q[waddr] && !flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      busy_cnt_q  <= '0;
      wb_orphan_q <= 1'b0;
      for (int k = 0; k < DEPTH; k++) rf_q[k] <= '0;
    end else begin
      busy_q      <= busy_d;
      busy_cnt_q  <= busy_cnt_d;
      wb_orphan_q <= wb_orphan_d;
      if (wr_hit) rf_q[waddr] <= wdata;
    end
  end

  assign busy_cnt  = busy_cnt_q;
  assign wb_orphan = wb_orphan_q;

endmodule
